// File: rtl/irq_ctrl.sv
// irq_ctrl -- machine-mode interrupt controller (external + optional timer).
//
// An asynchronous external line is synchronized, edge-detected and latched
// into MEIP. An optional 32-bit mtime/mtimecmp pair produces MTIP. Eligible
// sources are arbitrated (external over timer) by a three-state FSM that
// raises a trap request to the pipeline and tracks the handler until MRET.
//
// Build option: define IRQ_TIMER_EN to implement mtime/mtimecmp/MTIP.
// Without it, mtime reads 0, MTIP is 0 and cmp_wr/cmp_wdata/mie_mtie are
// ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   ext_irq      in   asynchronous external interrupt line
//   mstatus_mie  in   global machine interrupt enable
//   mie_meie     in   external interrupt enable
//   mie_mtie     in   timer interrupt enable
//   cmp_wr       in   mtimecmp write strobe
//   cmp_wdata    in   [31:0] mtimecmp write data
//   ack          in   pipeline has taken the trap
//   mret         in   MRET retired
//   irq_req      out  trap request (registered)
//   irq_cause    out  [31:0] mcause for the pending request
//   mip          out  [31:0] pending view: bit 11 MEIP, bit 7 MTIP
//   mtime        out  [31:0] free-running timer
//   in_handler   out  high while in HANDLER
//   dbg_state    out  [1:0] FSM state (0 IDLE, 1 REQ, 2 HANDLER)
//
// Handshake: irq_req rises when the FSM enters REQ and stays high, with
// irq_cause frozen, until a cycle in which ack is high; the FSM leaves REQ
// on that edge. ack outside REQ and mret outside HANDLER have no effect.

module irq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        cmp_wr,
    input  logic [31:0] cmp_wdata,
    input  logic        ack,
    input  logic        mret,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [31:0] mip,
    output logic [31:0] mtime,
    output logic        in_handler,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIM = 32'h8000_0007;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] w_next_cause;
    logic [31:0] r_irq_cause;
    logic        r_irq_req;
    logic        r_in_handler;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_prev;
    logic        r_meip;
    logic        w_ext_edge;
    logic        w_ack_ext;
    logic        w_mtip;
    logic        w_ext_elig;
    logic        w_tim_elig;

    // ------------------------------------------------------------------
    // External source: 2-flop synchronizer, rising-edge detect, MEIP latch
    // ------------------------------------------------------------------
    assign w_ext_edge = r_sync2 & ~r_sync_prev;
    // MEIP is consumed only when the trap actually taken is the external one.
    assign w_ack_ext  = (r_state == ST_REQ) && ack && (r_irq_cause == CAUSE_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_meip      <= 1'b0;
        end else begin
            r_sync1     <= ext_irq;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            // A fresh edge in the ack cycle beats the clear.
            if (w_ext_edge) begin
                r_meip <= 1'b1;
            end else if (w_ack_ext) begin
                r_meip <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer source
    // ------------------------------------------------------------------
`ifdef IRQ_TIMER_EN
    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 32'h0000_0000;
            r_mtimecmp <= 32'hFFFF_FFFF;
        end else begin
            r_mtime <= r_mtime + 32'd1;
            if (cmp_wr) begin
                r_mtimecmp <= cmp_wdata;
            end
        end
    end

    assign w_mtip     = (r_mtime >= r_mtimecmp);
    assign mtime      = r_mtime;
    assign w_tim_elig = w_mtip & mie_mtie;
`else
    logic w_unused_timer;

    assign w_unused_timer = ^{cmp_wr, cmp_wdata, mie_mtie};
    assign w_mtip         = 1'b0;
    assign mtime          = 32'h0000_0000;
    assign w_tim_elig     = 1'b0;
`endif

    assign w_ext_elig = r_meip & mie_meie;
    assign mip        = {20'd0, r_meip, 3'd0, w_mtip, 7'd0};

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_irq_req    <= 1'b0;
            r_in_handler <= 1'b0;
            r_irq_cause  <= 32'h0000_0000;
        end else begin
            r_state      <= w_next_state;
            r_irq_req    <= (w_next_state == ST_REQ);
            r_in_handler <= (w_next_state == ST_HANDLER);
            r_irq_cause  <= w_next_cause;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_irq_cause;
        case (r_state)
            ST_IDLE: begin
                if (mstatus_mie && (w_ext_elig || w_tim_elig)) begin
                    w_next_state = ST_REQ;
                    w_next_cause = w_ext_elig ? CAUSE_EXT : CAUSE_TIM;
                end
            end
            ST_REQ: begin
                // Enables are not looked at here: a raised request is never withdrawn.
                if (ack) begin
                    w_next_state = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (mret) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign irq_req    = r_irq_req;
    assign irq_cause  = r_irq_cause;
    assign in_handler = r_in_handler;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam logic [31:0] CE = 32'h8000_000B;
    localparam logic [31:0] CT = 32'h8000_0007;
    localparam logic [31:0] PE = 32'h0000_0800;
    localparam logic [31:0] PT = 32'h0000_0080;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        ext_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        cmp_wr;
    logic [31:0] cmp_wdata;
    logic        ack;
    logic        mret;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [31:0] mip;
    logic [31:0] mtime;
    logic        in_handler;
    logic [1:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ext_irq    (ext_irq),
        .mstatus_mie(mstatus_mie),
        .mie_meie   (mie_meie),
        .mie_mtie   (mie_mtie),
        .cmp_wr     (cmp_wr),
        .cmp_wdata  (cmp_wdata),
        .ack        (ack),
        .mret       (mret),
        .irq_req    (irq_req),
        .irq_cause  (irq_cause),
        .mip        (mip),
        .mtime      (mtime),
        .in_handler (in_handler),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic me,
                         input logic a, input logic mr);
        rst         = r;
        ext_irq     = e;
        mstatus_mie = m;
        mie_meie    = me;
        ack         = a;
        mret        = mr;
    endtask

    // Waits a bounded number of cycles for irq_req, then checks the cause
    // against the head of the expected queue.
    task automatic expect_req(input string name, input int budget);
        int          n;
        logic [31:0] exp;
        n = 0;
        while (!irq_req && n < budget) begin
            tick();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (!irq_req) begin
            checks++;
            errors++;
            $display("FAIL %s: irq_req timeout after %0d cycles, expected cause %h", name, budget, exp);
        end else begin
            chk({name, " cause"}, irq_cause, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        ext;
        logic        mie;
        logic        meie;
        logic        ack;
        logic        mret;
        logic        req;
        logic [31:0] cause;
        logic [31:0] mip;
        logic        inh;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mie_mtie  = 1'b0;
        cmp_wr    = 1'b0;
        cmp_wdata = 32'h0;

        //          rst ext mie meie ack mret | req cause mip inh
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,PE,   1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,CE,   PE,   1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,CE,   32'h0,1'b1};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,CE,   32'h0,1'b1};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,CE,   32'h0,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,CE,   32'h0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,CE,   32'h0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,CE,   32'h0,1'b0};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,CE,   32'h0,1'b0};
        tbl[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,CE,   32'h0,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,CE,   PE,   1'b0};
        tbl[16] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[17] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,CE,   32'h0,1'b1};
        tbl[18] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[19] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[20] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[21] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,PE,   1'b0};
        tbl[22] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,PE,   1'b0};
        tbl[23] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[24] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[25] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[26] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,32'h0,1'b0};
        tbl[27] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,PE,   1'b0};
        tbl[28] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[29] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[30] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[31] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[32] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[33] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[34] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,CE,   PE,   1'b1};
        tbl[35] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,CE,   PE,   1'b0};
        tbl[36] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,CE,   PE,   1'b0};
        tbl[37] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,CE,   32'h0,1'b1};
        tbl[38] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,CE,   32'h0,1'b0};

        // ---------------- table-driven external-source flow ----------------
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].ext, tbl[i].mie, tbl[i].meie, tbl[i].ack, tbl[i].mret);
            tick();
            chk($sformatf("row%0d irq_req", i),    {31'd0, irq_req},    {31'd0, tbl[i].req});
            chk($sformatf("row%0d irq_cause", i),  irq_cause,           tbl[i].cause);
            chk($sformatf("row%0d mip", i),        mip,                 tbl[i].mip);
            chk($sformatf("row%0d in_handler", i), {31'd0, in_handler}, {31'd0, tbl[i].inh});
            if (tbl[i].rst) begin
                chk($sformatf("row%0d mtime", i), mtime, 32'h0);
            end
        end

`ifdef IRQ_TIMER_EN
        // ---------------- timer: compare at 20 ----------------
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mie_mtie = 1'b0;
        tick();
        chk("tmr reset mtime", mtime, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mie_mtie  = 1'b1;
        cmp_wr    = 1'b1;
        cmp_wdata = 32'd20;
        tick();
        chk("tmr mtime after 1", mtime, 32'd1);
        cmp_wr = 1'b0;
        for (int n = 0; n < 40 && mtime < 32'd20; n++) begin
            chk("tmr no early req", {31'd0, irq_req}, 32'd0);
            tick();
        end
        chk("tmr mtime at cmp", mtime, 32'd20);
        chk("tmr mip at cmp", mip, PT);
        chk("tmr req not yet", {31'd0, irq_req}, 32'd0);
        tick();
        chk("tmr req", {31'd0, irq_req}, 32'd1);
        chk("tmr cause", irq_cause, CT);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("tmr in_handler", {31'd0, in_handler}, 32'd1);
        cmp_wr    = 1'b1;
        cmp_wdata = 32'hFFFF_FFFF;
        tick();
        cmp_wr = 1'b0;
        chk("tmr mip after cmp max", mip, 32'h0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("tmr back to idle", {31'd0, in_handler}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("tmr no re-request", {31'd0, irq_req}, 32'd0);
        end

        // ---------------- both sources pending ----------------
        mstatus_mie = 1'b0;
        cmp_wr      = 1'b1;
        cmp_wdata   = 32'h0;
        tick();
        cmp_wr   = 1'b0;
        mie_meie = 1'b1;
        ext_irq  = 1'b1;
        repeat (3) tick();
        chk("both mip", mip, PE | PT);
        mstatus_mie = 1'b1;
        exp_q.push_back(CE);
        expect_req("both first", 2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("both meip cleared", mip, PT);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("both idle", {31'd0, irq_req}, 32'd0);
        exp_q.push_back(CT);
        expect_req("both second", 3);
`else
        // ---------------- timer absent: no MTIP, no mtime ----------------
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        mie_mtie  = 1'b1;
        cmp_wr    = 1'b1;
        cmp_wdata = 32'h0;
        tick();
        cmp_wr = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("notmr mtime", mtime, 32'h0);
            chk("notmr mip", mip, 32'h0);
            chk("notmr no req", {31'd0, irq_req}, 32'd0);
        end
        ext_irq = 1'b1;
        exp_q.push_back(CE);
        expect_req("notmr ext req", 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port ext_irq, input, 1 bit: asynchronous external interrupt line.
REQ-005 The block SHALL have port mstatus_mie, input, 1 bit: global machine interrupt enable.
REQ-006 The block SHALL have port mie_meie, input, 1 bit: external interrupt enable.
REQ-007 The block SHALL have port mie_mtie, input, 1 bit: timer interrupt enable.
REQ-008 The block SHALL have port cmp_wr, input, 1 bit: mtimecmp write strobe.
REQ-009 The block SHALL have port cmp_wdata, input, 32 bits: mtimecmp write data.
REQ-010 The block SHALL have port ack, input, 1 bit: pipeline has taken the trap.
REQ-011 The block SHALL have port mret, input, 1 bit: MRET retired.
REQ-012 The block SHALL have port irq_req, output, 1 bit: trap request to the pipeline/CSR file.
REQ-013 The block SHALL have port irq_cause, output, 32 bits: mcause value for the pending request.
REQ-014 The block SHALL have port mip, output, 32 bits: pending view, with bit 11 = MEIP, bit 7 = MTIP, all other bits 0.
REQ-015 The block SHALL have port mtime, output, 32 bits: free-running timer.
REQ-016 The block SHALL have port in_handler, output, 1 bit: high while in state HANDLER.

Function
REQ-017 ext_irq SHALL pass through a 2-flop synchronizer; a 0->1 edge of the synchronized signal SHALL set MEIP one cycle after the second flop.
REQ-018 MEIP SHALL clear in the cycle ack is accepted with irq_cause = 0x8000000B; a new edge in that same cycle SHALL win and leave MEIP set.
REQ-019 mtime SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-020 MTIP SHALL be combinational: (mtime >= mtimecmp), unsigned.
REQ-021 A cmp_wr SHALL load mtimecmp on the next edge.
REQ-022 Eligible sources SHALL be: external = MEIP & mie_meie; timer = MTIP & mie_mtie.
REQ-023 External SHALL have priority over timer; the external cause is 0x8000000B and the timer cause is 0x80000007.
REQ-024 The FSM SHALL have states IDLE, REQ, HANDLER.
REQ-025 In IDLE, when mstatus_mie is high and any source is eligible, the FSM SHALL move to REQ on the next edge and latch irq_cause.
REQ-026 In REQ, irq_req SHALL be 1 and irq_cause SHALL be held stable until ack; the request SHALL NOT be retracted even if enables drop.
REQ-027 REQ with ack SHALL move to HANDLER on the next edge; irq_req SHALL be 0 from that edge.
REQ-028 HANDLER with mret SHALL move to IDLE; a still-eligible source SHALL then re-request after one IDLE cycle.
REQ-029 ack outside REQ SHALL be ignored, and mret outside HANDLER SHALL be ignored.
REQ-030 irq_req SHALL be registered (state==REQ), giving a latency of 1 cycle from an eligible condition in IDLE.

Reset
REQ-031 On rst, the block SHALL set state = IDLE, irq_req = 0, irq_cause = 0, in_handler = 0, MEIP = 0, synchronizer flops = 0, mtime = 0, and mtimecmp = 0xFFFFFFFF.
REQ-032 rst SHALL dominate every other input, including a reset applied mid-REQ or mid-HANDLER.

Configuration
REQ-033 With macro IRQ_TIMER_EN defined, the mtime/mtimecmp/MTIP logic SHALL be implemented as described above.
REQ-034 Without IRQ_TIMER_EN, mtime SHALL read 0, MTIP SHALL be 0, cmp_wr SHALL be ignored, and only the external source SHALL exist.

Verification
REQ-035 Ext edge with mstatus_mie=1 and mie_meie=1 -> irq_req=1 with cause 0x8000000B within 4 cycles; ack -> in_handler=1 and MEIP=0; mret -> IDLE.
REQ-036 (IRQ_TIMER_EN) After rst, write cmp_wdata=20 with mie_mtie=1 and mstatus_mie=1 -> irq_req=1 with cause 0x80000007 one cycle after mtime reaches 20; write cmp=0xFFFFFFFF in HANDLER, then mret -> no new request.
REQ-037 Ext edge and MTIP both eligible -> cause 0x8000000B first; after mret, cause 0x80000007.
REQ-038 In REQ, drop mstatus_mie -> irq_req stays 1 with cause unchanged until ack.
REQ-039 ack held in IDLE and mret held in REQ -> no state change; rst asserted mid-HANDLER -> all outputs at reset values on the next edge.
